// File: rtl/shift_register_univ.sv
// Universal register: load, clear and multi-cycle shift/rotate by a
// programmable amount, one bit per enabled clock, with start/busy/done.
module shift_register_univ #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_SHL   = 3'd1;
    localparam logic [2:0] OP_SHR   = 3'd2;
    localparam logic [2:0] OP_ASR   = 3'd3;
    localparam logic [2:0] OP_ROL   = 3'd4;
    localparam logic [2:0] OP_ROR   = 3'd5;
    localparam logic [2:0] OP_CLEAR = 3'd6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic             sout_q;
    logic             done_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] cnt_q;
    logic [WIDTH:0]   step_idle_d;
    logic [WIDTH:0]   step_busy_d;

    // One single-bit step: returns {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] shift1(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] v,
        input logic             s
    );
        logic [WIDTH:0] r;
        r = {1'b0, v};
        case (o)
            OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], s};
            OP_SHR:  r = {v[0], s, v[WIDTH-1:1]};
            OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    always_comb begin
        step_idle_d = shift1(op, q_q, sin);
        step_busy_d = shift1(op_q, q_q, sin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= OP_LOAD;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (en) begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                OP_LOAD: begin
                                    q_q    <= d;
                                    done_q <= 1'b1;
                                end
                                OP_CLEAR: begin
                                    q_q    <= '0;
                                    sout_q <= 1'b0;
                                    done_q <= 1'b1;
                                end
                                OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR: begin
                                    if (amt == '0) begin
                                        done_q <= 1'b1;
                                    end else begin
                                        sout_q <= step_idle_d[WIDTH];
                                        q_q    <= step_idle_d[WIDTH-1:0];
                                        if (amt == AMT_W'(1)) begin
                                            done_q <= 1'b1;
                                        end else begin
                                            op_q    <= op;
                                            cnt_q   <= amt - AMT_W'(1);
                                            state_q <= SHIFT;
                                        end
                                    end
                                end
                                default: done_q <= 1'b1;
                            endcase
                        end
                    end
                    SHIFT: begin
                        sout_q <= step_busy_d[WIDTH];
                        q_q    <= step_busy_d[WIDTH-1:0];
                        cnt_q  <= cnt_q - AMT_W'(1);
                        if (cnt_q == AMT_W'(1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = (state_q == SHIFT);
    assign done = done_q;

endmodule
